// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, burst limit and FSM state type for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH    = 12;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned SINGLE_ACCESS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Two-way winner select with round-robin pointer.
// Defining MEM_ARB_FIXED_PRIO_EN makes requester 0 always win and drops the pointer.
module rr_picker (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       win_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_sig;
  assign unused_sig = ^{clk_i, rst_ni, take_i, req_i[1]};
  assign win_o      = ~req_i[0];
`else
  logic ptr_q, ptr_d;

  // ptr_q names the requester favoured on a tie; after a grant it points at the loser.
  assign win_o = req_i[1] & (~req_i[0] | ptr_q);
  assign ptr_d = take_i ? ~win_o : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one memory port between the command path (0) and tile FSM (1).
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = mem_port_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = mem_port_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned MAX_BURST  = mem_port_arbiter_pkg::SINGLE_ACCESS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [1:0]              req,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]              req_len,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              grant,
  output logic [2:0]              beat_idx,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [2:0]              rd_idx,
  output logic [1:0]              done
);
  import mem_port_arbiter_pkg::*;

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            last_q, last_d;
  logic [2:0]            beat_q, beat_d;
  logic [1:0]            rd_valid_q, rd_valid_d;
  logic [2:0]            rd_idx_q, rd_idx_d;

  logic                  win;
  logic                  take;
  logic [3:0]            len_sel;
  logic [3:0]            eff_len;

  rr_picker u_picker (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .req_i  (req),
    .take_i (take),
    .win_o  (win)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    write_d    = write_q;
    base_d     = base_q;
    last_d     = last_q;
    beat_d     = beat_q;
    rd_valid_d = '0;
    rd_idx_d   = rd_idx_q;
    take       = 1'b0;
    grant      = '0;
    done       = '0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;

    len_sel = win ? req_len[7:4] : req_len[3:0];
    if (len_sel == 4'd0) begin
      eff_len = 4'd1;
    end else if (32'(len_sel) > MAX_BURST) begin
      eff_len = 4'(MAX_BURST);
    end else begin
      eff_len = len_sel;
    end

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          take    = 1'b1;
          owner_d = win;
          write_d = win ? req_write[1] : req_write[0];
          base_d  = win ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
          last_d  = 3'(eff_len - 4'd1);
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        grant[owner_q] = 1'b1;
        mem_addr       = base_q + ADDR_WIDTH'(beat_q);
        mem_data       = owner_q ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                 : req_wdata[0 +: DATA_WIDTH];
        mem_write      = write_q;
        mem_read       = ~write_q;
        if (!write_q) begin
          rd_valid_d[owner_q] = 1'b1;
          rd_idx_d            = beat_q;
        end
        if (beat_q == last_q) begin
          done[owner_q] = 1'b1;
          beat_d        = '0;
          state_d       = ST_IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      base_q     <= '0;
      last_q     <= '0;
      beat_q     <= '0;
      rd_valid_q <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      base_q     <= base_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Memory returns read data one cycle after the beat, i.e. in the rd_valid cycle,
  // so the word is forwarded directly alongside the registered strobe and index.
  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign rd_data  = (rd_valid_q != 2'b00) ? mem_rdata : '0;
  assign beat_idx = beat_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 12, memory word address width.
REQ-002 Parameter: DATA_WIDTH, 32, memory word width.
REQ-003 Parameter: MAX_BURST, 8, maximum beats per grant (equals SINGLE_ACCESS).
REQ-004 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: req  in  2  per-requester request; bit 0 is command path, bit 1 is tile FSM.
REQ-007 Port: req_write  in  2x1  per-requester direction; 1 means write, 0 means read.
REQ-008 Port: req_addr  in  2xADDR_WIDTH  per-requester burst base address.
REQ-009 Port: req_len  in  2x4  per-requester beat count.
REQ-010 Port: req_wdata  in  2xDATA_WIDTH  write data from each requester, sampled per beat.
REQ-011 Port: mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after a read beat.
REQ-012 Port: grant  out  2  one-hot owner of the current burst.
REQ-013 Port: beat_idx  out  3  index of the current beat within the burst.
REQ-014 Port: mem_addr, mem_data, mem_read, mem_write  out  ADDR_WIDTH/DATA_WIDTH/1/1  memory port drive.
REQ-015 Port: rd_valid  out  2  per-requester read-data strobe.
REQ-016 Port: rd_data, rd_idx  out  DATA_WIDTH/3  returned read word and its beat index.
REQ-017 Port: done  out  2  one-cycle pulse to the owner on the last beat.

Function
REQ-018 The FSM SHALL have states IDLE and BURST.
REQ-019 IDLE with req≠0: the arbiter SHALL register the winner and its write/addr/len, then enter BURST next cycle; the first beat is driven the cycle after the req is sampled.
REQ-020 When both requesters request, the arbiter SHALL use round-robin; the pointer favours the requester that did not win last, and after reset it favours requester 0.
REQ-021 A req_len of 0 SHALL be treated as 1; a value above MAX_BURST SHALL be clamped to MAX_BURST.
REQ-022 In BURST, beat k SHALL drive mem_addr = base+k, wrapping mod 2^ADDR_WIDTH.
REQ-023 In BURST, beat k SHALL assert exactly one of mem_read or mem_write.
REQ-024 In BURST, mem_data SHALL equal req_wdata of the owner, combinationally.
REQ-025 grant SHALL be held for the entire burst; owner deassertion of req mid-burst is ignored, and the burst completes.
REQ-026 The done bit of the owner SHALL pulse on the last beat; the FSM returns to IDLE next cycle, so there is at least 1 idle cycle between bursts.
REQ-027 On a read, rd_valid, rd_data and rd_idx SHALL be registered 1 cycle after each read beat, including the beat following the return to IDLE.
REQ-028 In IDLE, mem_read, mem_write and grant SHALL be 0, and mem_addr and mem_data SHALL be 0.
REQ-029 Requester inputs of the non-owner SHALL have no effect during BURST.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE and clear grant, done, rd_valid, beat_idx, the RR pointer and all latched request fields to 0.
REQ-031 Reset mid-burst SHALL abort the burst with no further memory strobes and no done pulse.

Configuration
REQ-032 With MEM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the RR pointer is removed.
REQ-033 Without MEM_ARB_FIXED_PRIO_EN, round-robin per REQ-020 SHALL apply.

Structure
REQ-034 ADDR_WIDTH, DATA_WIDTH, SINGLE_ACCESS and the arbiter state enum SHALL live in the shared package.
REQ-035 The arbiter SHALL contain one sub-module, rr_picker: a 2-way combinational winner select plus pointer register.

Verification
REQ-036 The bench SHALL cover: only req[1], write, addr 500, len 8 -> writes at 500..507 on consecutive cycles, grant=2'b10, and done[1] at beat 7.
REQ-037 The bench SHALL cover: both req held, len 1, after reset -> grant order 0,1,0,1, with 1 idle cycle between grants.
REQ-038 The bench SHALL cover: read, addr 4094, len 4 -> addresses 4094, 4095, 0, 1, and rd_valid one cycle after each beat with rd_idx 0..3.
REQ-039 The bench SHALL cover: len 0 -> 1 beat; len 12 -> 8 beats.
REQ-040 The bench SHALL cover: reset_n low at beat 3 of 8 -> strobes stop immediately, no done, and IDLE after release.
REQ-041 The bench SHALL cover: MEM_ARB_FIXED_PRIO_EN defined with both req held -> requester 0 is granted every time.
